// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and sizing for the cache miss/refill controller.
// Holds the refill FSM state encoding, the cache address layout and the block-size helper.
package cache_refill_ctrl_pkg;

  localparam int unsigned DEF_RAM_ADDRESS_BITS = 10;
  localparam int unsigned DEF_DATA_BITS        = 32;
  localparam int unsigned DEF_BLOCK_BITS       = 2;
  localparam int unsigned DEF_INDEX_BITS       = 4;
  localparam int unsigned DEF_TAG_BITS         = DEF_RAM_ADDRESS_BITS - DEF_INDEX_BITS - DEF_BLOCK_BITS;

  function automatic int unsigned block_size(input int unsigned block_bits);
    return 32'd1 << block_bits;
  endfunction

  localparam int unsigned BLOCK_SIZE = block_size(DEF_BLOCK_BITS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    DONE
  } refill_state_t;

  typedef struct packed {
    logic [DEF_TAG_BITS-1:0]   tag;
    logic [DEF_INDEX_BITS-1:0] index;
    logic [DEF_BLOCK_BITS-1:0] offset;
  } cache_address_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle between cache, refill controller and RAM request/response channel.
// The controller takes the slave view; the surrounding cache/RAM environment takes the master view.
interface cache_refill_ctrl_if #(
    parameter int unsigned RAM_ADDRESS_BITS = 10,
    parameter int unsigned DATA_BITS        = 32
);

    logic                        miss_valid;
    logic [RAM_ADDRESS_BITS-1:0] miss_addr;
    logic                        miss_ready;

    logic                        wt_valid;
    logic [RAM_ADDRESS_BITS-1:0] wt_addr;
    logic [DATA_BITS-1:0]        wt_data;
    logic                        wt_ready;

    logic                        ram_req_valid;
    logic                        ram_req_ready;
    logic                        ram_req_we;
    logic [RAM_ADDRESS_BITS-1:0] ram_req_addr;
    logic [DATA_BITS-1:0]        ram_req_wdata;
    logic                        ram_rsp_valid;
    logic [DATA_BITS-1:0]        ram_rsp_data;

    logic                        fill_valid;
    logic [RAM_ADDRESS_BITS-1:0] fill_addr;
    logic [DATA_BITS-1:0]        fill_data;
    logic                        fill_last;
    logic                        crit_valid;
    logic [DATA_BITS-1:0]        crit_data;

    modport slave (
        input  miss_valid, miss_addr,
        input  wt_valid, wt_addr, wt_data,
        input  ram_req_ready, ram_rsp_valid, ram_rsp_data,
        output miss_ready, wt_ready,
        output ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata,
        output fill_valid, fill_addr, fill_data, fill_last,
        output crit_valid, crit_data
    );

    modport master (
        output miss_valid, miss_addr,
        output wt_valid, wt_addr, wt_data,
        output ram_req_ready, ram_rsp_valid, ram_rsp_data,
        input  miss_ready, wt_ready,
        input  ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata,
        input  fill_valid, fill_addr, fill_data, fill_last,
        input  crit_valid, crit_data
    );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss/refill controller: fetches the whole block around a missed word, streams it to the
// fill port, forwards the critical word, and arbitrates write-through stores onto the RAM channel.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
    parameter int unsigned DATA_BITS        = DEF_DATA_BITS,
    parameter int unsigned BLOCK_BITS       = DEF_BLOCK_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cache_refill_ctrl_if.slave       bus,
    output logic                     busy
);

    localparam int unsigned          BLK      = block_size(BLOCK_BITS);
    localparam logic [BLOCK_BITS-1:0] LAST_OFS = BLOCK_BITS'(BLK - 1);

    refill_state_t state, state_nxt;

    logic [BLOCK_BITS-1:0]       req_cnt;
    logic [BLOCK_BITS-1:0]       rsp_cnt;
    logic [BLOCK_BITS:0]         out_cnt;
    logic [RAM_ADDRESS_BITS-1:0] lat_addr;
    logic [DATA_BITS-1:0]        lat_data;

    logic [RAM_ADDRESS_BITS-BLOCK_BITS-1:0] tag_index;
    logic [BLOCK_BITS-1:0]                  offset;

    logic wt_accept;
    logic miss_accept;
    logic req_fire;
    logic rsp_accept;
    logic rsp_final;

    assign tag_index = lat_addr[RAM_ADDRESS_BITS-1:BLOCK_BITS];
    assign offset    = lat_addr[BLOCK_BITS-1:0];
    assign busy      = (state != IDLE);

    // Responses only count while a read of the current block is actually in flight;
    // anything else (e.g. stragglers from a block abandoned by reset) is dropped.
    assign rsp_accept = ((state == RD_REQ) || (state == RD_WAIT)) &&
                        bus.ram_rsp_valid && (out_cnt != '0);
    assign rsp_final  = rsp_accept && (rsp_cnt == LAST_OFS);
    assign req_fire   = (state == RD_REQ) && bus.ram_req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        wt_accept         = 1'b0;
        miss_accept       = 1'b0;
        bus.ram_req_valid = 1'b0;
        bus.ram_req_we    = 1'b0;
        bus.ram_req_addr  = '0;
        bus.ram_req_wdata = '0;

        unique case (state)
            IDLE: begin
                if (reset_n) begin
                    if (bus.wt_valid) begin
                        wt_accept = 1'b1;
                        state_nxt = WRITE;
                    end else if (bus.miss_valid) begin
                        miss_accept = 1'b1;
                        state_nxt   = RD_REQ;
                    end
                end
            end
            WRITE: begin
                bus.ram_req_valid = 1'b1;
                bus.ram_req_we    = 1'b1;
                bus.ram_req_addr  = lat_addr;
                bus.ram_req_wdata = lat_data;
                if (bus.ram_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                bus.ram_req_valid = 1'b1;
                bus.ram_req_addr  = {tag_index, req_cnt};
                if (bus.ram_req_ready && (req_cnt == LAST_OFS)) begin
                    state_nxt = RD_WAIT;
                end
                if (rsp_final) begin
                    state_nxt = DONE;
                end
            end
            RD_WAIT: begin
                if (rsp_final) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        bus.wt_ready   = wt_accept;
        bus.miss_ready = miss_accept;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_cnt        <= '0;
            rsp_cnt        <= '0;
            out_cnt        <= '0;
            lat_addr       <= '0;
            lat_data       <= '0;
            bus.fill_valid <= 1'b0;
            bus.fill_addr  <= '0;
            bus.fill_data  <= '0;
            bus.fill_last  <= 1'b0;
            bus.crit_valid <= 1'b0;
            bus.crit_data  <= '0;
        end else begin
            if (wt_accept) begin
                lat_addr <= bus.wt_addr;
                lat_data <= bus.wt_data;
            end
            if (miss_accept) begin
                lat_addr <= bus.miss_addr;
                req_cnt  <= '0;
                rsp_cnt  <= '0;
                out_cnt  <= '0;
            end else begin
                if (req_fire) begin
                    req_cnt <= req_cnt + 1'b1;
                end
                if (rsp_accept) begin
                    rsp_cnt <= rsp_cnt + 1'b1;
                end
                unique case ({req_fire, rsp_accept})
                    2'b10:   out_cnt <= out_cnt + 1'b1;
                    2'b01:   out_cnt <= out_cnt - 1'b1;
                    default: out_cnt <= out_cnt;
                endcase
            end

            bus.fill_valid <= rsp_accept;
            bus.fill_last  <= rsp_final;
            bus.crit_valid <= rsp_accept && (rsp_cnt == offset);
            if (rsp_accept) begin
                bus.fill_addr <= {tag_index, rsp_cnt};
                bus.fill_data <= bus.ram_rsp_data;
                if (rsp_cnt == offset) begin
                    bus.crit_data <= bus.ram_rsp_data;
                end
            end
        end
    end

    a_rsp_outstanding : assert property (
        @(posedge clk) disable iff (!reset_n)
        (bus.ram_rsp_valid && ((state == RD_REQ) || (state == RD_WAIT))) |-> (out_cnt != '0)
    ) else $error("ram_rsp_valid with no read outstanding");

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed misses/stores against a small RAM model,
// expected RAM requests and fills queued by stimulus and checked by an independent monitor.
module tb_cache_refill_ctrl;
    import cache_refill_ctrl_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned BB = 2;
    localparam int unsigned BS = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          crit;
    } fill_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    cache_refill_ctrl_if #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW)) bus ();

    cache_refill_ctrl #(
        .RAM_ADDRESS_BITS(AW),
        .DATA_BITS(DW),
        .BLOCK_BITS(BB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .busy(busy)
    );

    always #5 clk = ~clk;

    fill_t exp_fill[$];
    req_t  exp_req[$];
    fill_t mon_fill;
    req_t  mon_req;
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    last_fill_cyc = -1;
    int    ready_mode = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {20'hC0DE0, 2'b00, a};
    endfunction

    function automatic logic [127:0] all_outs();
        return {bus.miss_ready, bus.wt_ready, bus.ram_req_valid, bus.ram_req_we,
                bus.ram_req_addr, bus.ram_req_wdata, bus.fill_valid, bus.fill_addr,
                bus.fill_data, bus.fill_last, bus.crit_valid, bus.crit_data, busy};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model: one-cycle read latency, no response backpressure
    initial begin : ram_model
        logic          hs;
        logic          hwe;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwdata;
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(AW'(i));
        bus.ram_req_ready = 1'b1;
        bus.ram_rsp_valid = 1'b0;
        bus.ram_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs     = (bus.ram_req_valid === 1'b1) && (bus.ram_req_ready === 1'b1);
            hwe    = bus.ram_req_we;
            haddr  = bus.ram_req_addr;
            hwdata = bus.ram_req_wdata;
            @(posedge clk);
            #1;
            bus.ram_rsp_valid = hs && !hwe;
            bus.ram_rsp_data  = (hs && !hwe) ? mem[haddr] : '0;
            if (hs && hwe) mem[haddr] = hwdata;
            bus.ram_req_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n && bus.ram_req_valid === 1'b1 && bus.ram_req_ready === 1'b1) begin
                if (exp_req.size() == 0) begin
                    chk("ram_req_unexpected", {bus.ram_req_we, bus.ram_req_addr}, '1);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("ram_req", {bus.ram_req_we, bus.ram_req_addr,
                                    mon_req.we ? bus.ram_req_wdata : mon_req.wdata}, mon_req);
                end
            end
            if (bus.fill_valid === 1'b1) begin
                if (bus.fill_last === 1'b1) last_fill_cyc = cyc;
                if (exp_fill.size() == 0) begin
                    chk("fill_unexpected", {bus.fill_addr, bus.fill_data}, '1);
                end else begin
                    mon_fill = exp_fill.pop_front();
                    chk("fill", {bus.fill_addr, bus.fill_data, bus.fill_last, bus.crit_valid}, mon_fill);
                    if (mon_fill.crit) chk("crit_data", bus.crit_data, mon_fill.data);
                end
            end else if (bus.crit_valid === 1'b1) begin
                chk("crit_without_fill", bus.crit_valid, 1'b0);
            end
        end
    end

    task automatic push_block(input logic [AW-1:0] a, input int n_req, input int n_fill);
        cache_address_t ca;
        logic [AW-1:0]  base;
        logic [AW-1:0]  w;
        ca   = a;
        base = {ca.tag, ca.index, BB'(0)};
        for (int i = 0; i < n_req; i++) exp_req.push_back('{1'b0, base + AW'(i), '0});
        for (int i = 0; i < n_fill; i++) begin
            w = base + AW'(i);
            exp_fill.push_back('{w, init_word(w), (i == BS - 1), (w == a)});
        end
    endtask

    task automatic do_miss(input logic [AW-1:0] a, output int acc);
        acc = -1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.miss_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        chk("miss_accept", (acc >= 0), 1'b1);
        @(posedge clk);
        #1;
        bus.miss_valid = 1'b0;
    endtask

    task automatic do_wt(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
        acc = -1;
        bus.wt_valid = 1'b1;
        bus.wt_addr  = a;
        bus.wt_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.wt_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        chk("wt_accept", (acc >= 0), 1'b1);
        @(posedge clk);
        #1;
        bus.wt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && exp_fill.size() == 0 && exp_req.size() == 0) break;
        end
        chk(name, {busy, 16'(exp_fill.size()), 16'(exp_req.size())}, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int acc;
        int acc_wt;
        int n_rdy;
        logic [7:0] busy_seen;

        bus.miss_valid = 1'b0;
        bus.miss_addr  = '0;
        bus.wt_valid   = 1'b0;
        bus.wt_addr    = '0;
        bus.wt_data    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", all_outs(), '0);
        @(posedge clk);
        #1;

        // 1: basic refill, critical word at offset 2
        push_block(10'h0A6, BS, BS);
        do_miss(10'h0A6, acc);
        wait_idle("t1_drain");
        chk("t1_latency", 32'(last_fill_cyc - acc), 32'd6);

        // 2: simultaneous store and miss, store goes first
        exp_req.push_back('{1'b1, 10'h010, 32'hDEADBEEF});
        push_block(10'h020, BS, BS);
        fork
            do_wt(10'h010, 32'hDEADBEEF, acc_wt);
            do_miss(10'h020, acc);
        join
        wait_idle("t2_drain");
        chk("t2_order", 32'(acc - acc_wt), 32'd2);
        chk("t2_ram_write", mem[10'h010], 32'hDEADBEEF);

        // 3: RAM ready pattern 1,0,0,1,...
        ready_mode = 1;
        push_block(10'h155, BS, BS);
        do_miss(10'h155, acc);
        wait_idle("t3_drain");
        ready_mode = 0;
        @(posedge clk);
        #1;

        // 4: reset one cycle after the second response
        push_block(10'h1E5, 3, 2);
        do_miss(10'h1E5, acc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("t4_reset_outputs", all_outs(), '0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        wait_idle("t4_no_late_fill");
        push_block(10'h1E7, BS, BS);
        do_miss(10'h1E7, acc);
        wait_idle("t4_refill_after_reset");

        // 5: miss held through the refill
        push_block(10'h2C3, BS, BS);
        n_rdy = 0;
        busy_seen = '0;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 10'h2C3;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) bus.miss_valid = 1'b0;
            @(negedge clk);
            if (bus.miss_ready === 1'b1) n_rdy++;
            busy_seen[k] = busy;
            @(posedge clk);
            #1;
        end
        chk("t5_miss_ready_once", 32'(n_rdy), 32'd1);
        chk("t5_busy_window", busy_seen, 8'b0111_1110);
        wait_idle("t5_drain");

        // 6: offset-0 miss at top of address space
        push_block(10'h3FC, BS, BS);
        do_miss(10'h3FC, acc);
        wait_idle("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
